// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, frame constants and parity helper for the PS/2 receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } ps2_state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    // Odd parity holds when data plus parity carries an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - synchronous first-word-fall-through byte queue
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot a full-queue push needs.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// rtl/ps2_rx_ctrl.sv - PS/2 device-to-host frame receiver; PS2_INHIBIT_EN adds ps2_clk_oe flow control
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overflow,
    output logic                 busy
`ifdef PS2_INHIBIT_EN
    ,
    output logic                 ps2_clk_oe
`endif
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TMAX     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_BIT = 4'(FRAME_BITS - 2);

    logic [SYNC_STAGES-1:0]  r_clk_sync;
    logic [SYNC_STAGES-1:0]  r_data_sync;
    logic                    r_clk_prev;
    ps2_state_t              r_state;
    logic [3:0]              r_bit_cnt;
    logic [TW-1:0]           r_tcnt;
    logic [FRAME_BITS-2:0]   r_shift;
    logic                    r_pend;
    logic                    r_pend_data;
    logic                    r_frame_err;
    logic                    r_overflow;

    logic                    w_clk_s;
    logic                    w_data_s;
    logic                    w_fall_raw;
    logic                    w_fall;
    logic                    w_idle_fall;
    logic                    w_idle_data;
    logic                    w_good;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_push_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s   = r_data_sync[SYNC_STAGES-1];
    assign w_fall_raw = r_clk_prev & ~w_clk_s;

`ifdef PS2_INHIBIT_EN
    localparam int            HOLD = SYNC_STAGES + 2;
    localparam int            HW   = $clog2(HOLD + 1);

    logic          r_clk_oe;
    logic [HW-1:0] r_hold;

    // Our own pull-down and its release echo back through the synchronizer; mask them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_oe <= 1'b0;
            r_hold   <= '0;
        end else if (!r_clk_oe && w_full && r_state == IDLE) begin
            r_clk_oe <= 1'b1;
        end else if (r_clk_oe && !w_full) begin
            r_clk_oe <= 1'b0;
            r_hold   <= HW'(HOLD);
        end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
        end
    end

    assign ps2_clk_oe = r_clk_oe;
    assign w_fall     = w_fall_raw & ~r_clk_oe & (r_hold == '0);
`else
    assign w_fall     = w_fall_raw;
`endif

    // A fall caught during CHECK is replayed as an IDLE fall one cycle later.
    assign w_idle_fall = w_fall | r_pend;
    assign w_idle_data = r_pend ? r_pend_data : w_data_s;
    assign w_good      = odd_parity_ok(r_shift[DATA_BITS-1:0], r_shift[DATA_BITS]) & r_shift[DATA_BITS+1];
    assign w_pop       = rx_valid & rx_ready;
    assign w_push_ok   = ~w_full | w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_tcnt      <= '0;
            r_shift     <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tcnt <= '0;
                    r_pend <= 1'b0;
                    if (w_idle_fall && !w_idle_data) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (w_fall) begin
                        r_shift   <= {w_data_s, r_shift[FRAME_BITS-2:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_tcnt    <= '0;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= CHECK;
                        end
                    end else if (r_tcnt == TMAX) begin
                        r_state     <= IDLE;
                        r_tcnt      <= '0;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                CHECK: begin
                    r_state <= IDLE;
                    if (!w_good) begin
                        r_frame_err <= 1'b1;
                    end else if (!w_push_ok) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_fall) begin
                        r_pend      <= 1'b1;
                        r_pend_data <= w_data_s;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  ((r_state == CHECK) & w_good & w_push_ok),
        .i_wdata (r_shift[DATA_BITS-1:0]),
        .i_pop   (w_pop),
        .o_rdata (rx_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx_valid  = ~w_empty;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb/tb_ps2_rx_ctrl.sv - self-checking bench for ps2_rx_ctrl
module tb_ps2_rx_ctrl;

    localparam int S    = 2;
    localparam int T    = 300;
    localparam int D    = 4;
    localparam int HALF = 20;
`ifdef PS2_INHIBIT_EN
    localparam int NRAND = 4;
`else
    localparam int NRAND = 6;
`endif

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       exp_ok;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic       busy;
`ifdef PS2_INHIBIT_EN
    logic       ps2_clk_oe;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_ferr = 0, n_ovf = 0, n_wide = 0;
    int t_ferr = 0, t_ovf = 0, t_valid = 0, t_last = 0;
    logic p_ferr = 1'b0, p_ovf = 1'b0, p_valid = 1'b0;

    ps2_rx_ctrl #(
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (T),
        .FIFO_DEPTH     (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .busy      (busy)
`ifdef PS2_INHIBIT_EN
        ,
        .ps2_clk_oe(ps2_clk_oe)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) begin
            n_ferr <= n_ferr + 1;
            t_ferr <= cyc;
            if (p_ferr) n_wide <= n_wide + 1;
        end
        if (overflow) begin
            n_ovf <= n_ovf + 1;
            t_ovf <= cyc;
            if (p_ovf) n_wide <= n_wide + 1;
        end
        if (rx_valid && !p_valid) t_valid <= cyc;
        p_ferr  <= frame_err;
        p_ovf   <= overflow;
        p_valid <= rx_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        t_last = cyc;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [10:0] f);
        send_bits(f, 0, 10);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        @(negedge clk);
        check({name, " valid"}, rx_valid, 1);
        check({name, " data"}, rx_data, exp);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    vec_t        vecs[7];
    logic [7:0]  q[$];
    int          f0, o0, exp_f, exp_o;
    logic [7:0]  d;
    logic        p, s, ok;
    int          kind;

    initial begin
        vecs[0] = '{8'h1C, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'h55, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h37, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'hA5, 1'b1, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overflow", overflow, 0);
        check("reset busy", busy, 0);
`ifdef PS2_INHIBIT_EN
        check("reset ps2_clk_oe", ps2_clk_oe, 0);
`endif
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Good frame: valid appears one cycle after CHECK
        send(mk(8'h1C, 1'b0, 1'b1));
        check("1C latency", t_valid - t_last, S + 2);
        check("1C busy", busy, 0);
        check("1C no err", n_ferr, 0);
        pop_check("1C pop", 8'h1C);
        @(negedge clk);
        check("1C empty valid", rx_valid, 0);
        check("1C empty data", rx_data, 0);

        // Table of frames
        for (int i = 0; i < 7; i++) begin
            f0 = n_ferr;
            send(mk(vecs[i].d, vecs[i].p, vecs[i].s));
            @(negedge clk);
            check($sformatf("vec%0d err", i), n_ferr - f0, vecs[i].exp_ok ? 0 : 1);
            check($sformatf("vec%0d valid", i), rx_valid, vecs[i].exp_ok);
            check($sformatf("vec%0d data", i), rx_data, vecs[i].exp_ok ? vecs[i].d : 8'h00);
            check($sformatf("vec%0d busy", i), busy, 0);
            if (!vecs[i].exp_ok) check($sformatf("vec%0d err time", i), t_ferr - t_last, S + 2);
            else pop_check($sformatf("vec%0d pop", i), vecs[i].d);
        end
        check("pulse width", n_wide, 0);

        // Timeout after start + 4 data bits
        send_bits(mk(8'h00, 1'b1, 1'b1), 0, 4);
        f0 = n_ferr;
        for (int i = 0; i < 3 * T && n_ferr == f0; i++) @(negedge clk);
        check("timeout fired", n_ferr - f0, 1);
        check("timeout time", t_ferr - t_last, T + S + 1);
        check("timeout busy", busy, 0);
        send(mk(8'hF0, 1'b1, 1'b1));
        pop_check("F0 pop", 8'hF0);

        // Fill past depth with consumer stalled
        o0 = n_ovf;
        for (int b = 1; b <= 5; b++) begin
            send(mk(8'(b), ~^(8'(b)), 1'b1));
`ifdef PS2_INHIBIT_EN
            if (b == 4) check("inhibit oe", ps2_clk_oe, 1);
`endif
        end
`ifdef PS2_INHIBIT_EN
        check("inhibit no overflow", n_ovf - o0, 0);
`else
        check("overflow count", n_ovf - o0, 1);
        check("overflow time", t_ovf - t_last, S + 2);
`endif
        for (int b = 1; b <= 4; b++) pop_check("ovf pop", 8'(b));
        @(negedge clk);
        check("ovf drained", rx_valid, 0);
        repeat (2 * HALF) @(posedge clk);
        #1;

        // Reset mid-frame
        send(mk(8'h33, 1'b1, 1'b1));
        send_bits(mk(8'hAA, 1'b1, 1'b1), 0, 3);
        check("pre-reset busy", busy, 1);
        check("pre-reset valid", rx_valid, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid reset valid", rx_valid, 0);
        check("mid reset data", rx_data, 0);
        check("mid reset busy", busy, 0);
        check("mid reset err", frame_err, 0);
        check("mid reset ovf", overflow, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        send_bits(mk(8'hAA, 1'b1, 1'b1), 4, 10);
        repeat (T + 50) @(posedge clk);
        #1;
        check("leftover valid", rx_valid, 0);
        send(mk(8'h5A, 1'b1, 1'b1));
        pop_check("5A pop", 8'h5A);

`ifndef PS2_INHIBIT_EN
        // Pop coincides with the full-queue push of 0x5A
        send(mk(8'h11, 1'b1, 1'b1));
        send(mk(8'h22, 1'b1, 1'b1));
        send(mk(8'h33, 1'b1, 1'b1));
        send(mk(8'h44, 1'b1, 1'b1));
        o0 = n_ovf;
        send_bits(mk(8'h5A, 1'b1, 1'b1), 0, 9);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (S + 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        check("pushpop no ovf", n_ovf - o0, 0);
        pop_check("pushpop 22", 8'h22);
        pop_check("pushpop 33", 8'h33);
        pop_check("pushpop 44", 8'h44);
        pop_check("pushpop 5A", 8'h5A);
        @(negedge clk);
        check("pushpop drained", rx_valid, 0);
`endif

        // Randomized frames against a queue model
        for (int b = 0; b < 3; b++) begin
            f0 = n_ferr;
            o0 = n_ovf;
            exp_f = 0;
            exp_o = 0;
            for (int k = 0; k < NRAND; k++) begin
                d    = 8'($urandom);
                kind = $urandom_range(0, 3);
                p    = ~^d;
                s    = 1'b1;
                if (kind == 1) p = ~p;
                if (kind == 2) s = 1'b0;
                send(mk(d, p, s));
                ok = ((($countones(d) + int'(p)) % 2) == 1) && s;
                if (!ok) exp_f++;
                else if (q.size() < D) q.push_back(d);
                else exp_o++;
            end
            check("rand err count", n_ferr - f0, exp_f);
            check("rand ovf count", n_ovf - o0, exp_o);
            while (q.size() > 0) pop_check("rand pop", q.pop_front());
            @(negedge clk);
            check("rand drained", rx_valid, 0);
            repeat (2 * HALF) @(posedge clk);
            #1;
        end
        check("final pulse width", n_wide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
